// File: rtl/ram_sp_arbiter_pkg.sv
// rtl/ram_sp_arbiter_pkg.sv - shared state encoding and default widths for the RAM port arbiter
package ram_sp_arbiter_pkg;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;
endpackage

// File: rtl/ram_sp_arbiter_if.sv
// rtl/ram_sp_arbiter_if.sv - one client's req/gnt transaction port plus its read return
interface ram_sp_arbiter_if
    import ram_sp_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_sp_arbiter_rr_grant2.sv
// rtl/ram_sp_arbiter_rr_grant2.sv - two-way round-robin grant with bounded burst ownership
module ram_sp_arbiter_rr_grant2
    import ram_sp_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic                   req0,
    input  logic                   req1,
    input  arb_state_t             state,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    input  logic                   last_owner,
    output logic                   gnt0,
    output logic                   gnt1
);
    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

    logic keep;
    assign keep = burst_cnt < BURST_LIM;

    // Contention only matters when both ask; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            case (state)
                ST_OWN0: begin
                    gnt0 = keep;
                    gnt1 = !keep;
                end
                ST_OWN1: begin
                    gnt1 = keep;
                    gnt0 = !keep;
                end
                default: begin
                    gnt0 = last_owner;
                    gnt1 = !last_owner;
                end
            endcase
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end
endmodule

// File: rtl/ram_sp_arbiter.sv
// rtl/ram_sp_arbiter.sv - shares one single-port sync-read RAM between two clients
module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sp_arbiter_if.slave   port0,
    ram_sp_arbiter_if.slave   port1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

    arb_state_t             state;
    logic                   last_owner;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] burst_inc;
    logic [ADDR_W-1:0]      addr_q;
    logic                   rvalid0_q;
    logic                   rvalid1_q;
    logic                   gnt0_raw;
    logic                   gnt1_raw;
    logic                   gnt0;
    logic                   gnt1;

    ram_sp_arbiter_rr_grant2 #(.BURST_MAX(BURST_MAX)) u_grant (
        .req0       (port0.req),
        .req1       (port1.req),
        .state      (state),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .gnt0       (gnt0_raw),
        .gnt1       (gnt1_raw)
    );

    // Grants imply a request, so a grant alone marks an accepted transaction.
    assign gnt0 = gnt0_raw & rst_n;
    assign gnt1 = gnt1_raw & rst_n;

    assign port0.gnt    = gnt0;
    assign port1.gnt    = gnt1;
    assign port0.rvalid = rvalid0_q;
    assign port1.rvalid = rvalid1_q;
    assign port0.rdata  = rvalid0_q ? ram_data_out : '0;
    assign port1.rdata  = rvalid1_q ? ram_data_out : '0;

    assign burst_inc = (burst_cnt >= BURST_LIM) ? burst_cnt : burst_cnt + BURST_CNT_W'(1);

    // Idle cycles park the address on the last granted one to keep the bus quiet.
    always_comb begin
        ram_address  = addr_q;
        ram_data_in  = '0;
        ram_write_en = 1'b0;
        if (gnt0) begin
            ram_address  = port0.addr;
            ram_data_in  = port0.wdata;
            ram_write_en = port0.we & port0.req;
        end else if (gnt1) begin
            ram_address  = port1.addr;
            ram_data_in  = port1.wdata;
            ram_write_en = port1.we & port1.req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            addr_q     <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~port0.we;
            rvalid1_q <= gnt1 & ~port1.we;
            if (gnt0 || gnt1) begin
                addr_q <= ram_address;
            end
            if (gnt0) begin
                state      <= ST_OWN0;
                last_owner <= 1'b0;
                burst_cnt  <= (state == ST_OWN0) ? burst_inc : BURST_CNT_W'(1);
            end else if (gnt1) begin
                state      <= ST_OWN1;
                last_owner <= 1'b1;
                burst_cnt  <= (state == ST_OWN1) ? burst_inc : BURST_CNT_W'(1);
            end else begin
                state     <= ST_IDLE;
                burst_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb/tb_ram_sp_arbiter.sv - self-checking bench: behavioural RAM plus history-based arbitration model
`timescale 1ns/1ps
module tb_ram_sp_arbiter;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sp_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) port0 ();
    ram_sp_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) port1 ();

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_write_en;

    ram_sp_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port0        (port0),
        .port1        (port1),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out)
    );

    // Single-port RAM with registered read address
    logic [7:0] mem [16];
    logic [3:0] ram_addr_q;
    logic       mem_fill  = 1'b0;
    logic       fill_zero = 1'b0;

    function automatic logic [7:0] pattern(input int i);
        return 8'(8'h40 + 3 * i);
    endfunction

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= fill_zero ? 8'h00 : pattern(i);
        end else if (ram_write_en) begin
            mem[ram_address] <= ram_data_in;
        end
        ram_addr_q <= ram_address;
    end
    assign ram_data_out = mem[ram_addr_q];

    int tests_run    = 0;
    int tests_failed = 0;

    // Arbitration model: owner of each past cycle (-1 = nothing accepted)
    int         acc_hist[$];
    int         last_acc;
    logic [7:0] model_mem [16];

    function automatic int exp_grant(input logic r0, input logic r1);
        int run;
        int prev;
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (acc_hist.size() == 0 || acc_hist[acc_hist.size()-1] == -1) return (last_acc == 0) ? 1 : 0;
        prev = acc_hist[acc_hist.size()-1];
        run  = 0;
        for (int i = acc_hist.size() - 1; i >= 0; i--) begin
            if (acc_hist[i] != prev) break;
            run++;
        end
        return (run >= BURST_MAX) ? 1 - prev : prev;
    endfunction

    task automatic cycle(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        @(negedge clk);
        port0.req = r0; port0.we = w0; port0.addr = a0; port0.wdata = d0;
        port1.req = r1; port1.we = w1; port1.addr = a1; port1.wdata = d1;
        #2;
    endtask

    task automatic do_reset(input logic zero);
        @(negedge clk);
        rst_n = 1'b0;
        port0.req = 1'b0; port0.we = 1'b0;
        port1.req = 1'b0; port1.we = 1'b0;
        fill_zero = zero;
        mem_fill  = 1'b1;
        @(negedge clk);
        mem_fill = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        port0.req = 1'b1; port0.we = 1'b1; port0.addr = 4'd1; port0.wdata = 8'h11;
        port1.req = 1'b1; port1.we = 1'b1; port1.addr = 4'd2; port1.wdata = 8'h22;
        #2;
        tests_run++; if (port0.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt0 got %b want 0", port0.gnt); end
        tests_run++; if (port1.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt1 got %b want 0", port1.gnt); end
        tests_run++; if (ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %b want 0", ram_write_en); end
        tests_run++; if (port0.rvalid !== 1'b0 || port1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got %b%b want 00", port0.rvalid, port1.rvalid); end
        tests_run++; if (port0.rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata0 got %h want 00", port0.rdata); end
        do_reset(1'b0);
    endtask

    task automatic test_single();
        do_reset(1'b0);
        cycle(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.gnt !== 1'b1 || port1.gnt !== 1'b0) begin tests_failed++; $display("FAIL single_wr_gnt got %b%b want 10", port0.gnt, port1.gnt); end
        tests_run++; if (ram_write_en !== 1'b1 || ram_address !== 4'd3 || ram_data_in !== 8'hA5) begin tests_failed++; $display("FAIL single_wr_bus got we=%b a=%h d=%h want 1 3 a5", ram_write_en, ram_address, ram_data_in); end
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.gnt !== 1'b1 || ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL single_rd_gnt got gnt0=%b we=%b want 1 0", port0.gnt, ram_write_en); end
        tests_run++; if (port0.rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_wr_no_rvalid got %b want 0", port0.rvalid); end
        cycle(1'b0, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.rvalid !== 1'b1 || port0.rdata !== 8'hA5) begin tests_failed++; $display("FAIL single_rd_data got v=%b d=%h want 1 a5", port0.rvalid, port0.rdata); end
        tests_run++; if (port1.rvalid !== 1'b0 || port1.gnt !== 1'b0) begin tests_failed++; $display("FAIL single_other_quiet got v=%b g=%b want 0 0", port1.rvalid, port1.gnt); end
        tests_run++; if (ram_address !== 4'd3 || ram_data_in !== 8'h00) begin tests_failed++; $display("FAIL single_idle_bus got a=%h d=%h want 3 00", ram_address, ram_data_in); end
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.rvalid !== 1'b0 || port0.rdata !== 8'h00) begin tests_failed++; $display("FAIL single_rvalid_pulse got v=%b d=%h want 0 00", port0.rvalid, port0.rdata); end
    endtask

    task automatic test_tie();
        int         exp_g[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        int         prev = -1;
        logic [3:0] prev_addr = 4'd0;
        logic [3:0] a0;
        logic [3:0] a1;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            a0 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom_range(0, 15));
            cycle(1'b1, 1'b0, a0, 8'h00, 1'b1, 1'b0, a1, 8'h00);
            tests_run++; if (port0.gnt !== (exp_g[i] == 0) || port1.gnt !== (exp_g[i] == 1)) begin tests_failed++; $display("FAIL tie_grant[%0d] got %b%b want owner %0d", i, port0.gnt, port1.gnt, exp_g[i]); end
            tests_run++; if (port0.rvalid !== (prev == 0) || port1.rvalid !== (prev == 1)) begin tests_failed++; $display("FAIL tie_rvalid[%0d] got %b%b want owner %0d", i, port0.rvalid, port1.rvalid, prev); end
            if (prev >= 0) begin
                tests_run++;
                if (((prev == 0) ? port0.rdata : port1.rdata) !== pattern(int'(prev_addr))) begin
                    tests_failed++; $display("FAIL tie_rdata[%0d] got %h want %h", i, (prev == 0) ? port0.rdata : port1.rdata, pattern(int'(prev_addr)));
                end
            end
            prev      = exp_g[i];
            prev_addr = (prev == 0) ? a0 : a1;
        end
    endtask

    task automatic test_isolation();
        logic [7:0] old_d = pattern(15);
        logic       wrote = 1'b0;
        logic       pend  = 1'b0;
        logic [7:0] pend_d = 8'h00;
        int         wcyc  = -1;
        do_reset(1'b0);
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 1'b0, 4'd15, 8'h00, (c >= 1) && !wrote, 1'b1, 4'd15, 8'h3C);
            tests_run++; if (port0.gnt === 1'b1 && port1.gnt === 1'b1) begin tests_failed++; $display("FAIL iso_both_gnt[%0d] got 11 want one-hot", c); end
            tests_run++; if (port0.rvalid !== pend || port1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL iso_rvalid[%0d] got %b%b want %b0", c, port0.rvalid, port1.rvalid, pend); end
            if (pend) begin
                tests_run++; if (port0.rdata !== pend_d) begin tests_failed++; $display("FAIL iso_rdata[%0d] got %h want %h", c, port0.rdata, pend_d); end
            end
            pend   = port0.gnt;
            pend_d = wrote ? 8'h3C : old_d;
            if (port1.gnt === 1'b1) begin
                wrote = 1'b1;
                wcyc  = c;
            end
        end
        tests_run++; if (wcyc != 4) begin tests_failed++; $display("FAIL iso_write_cycle got %0d want 4", wcyc); end
    endtask

    task automatic test_burst_yield();
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b0, 4'(c), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
            tests_run++; if (port0.gnt !== 1'b1) begin tests_failed++; $display("FAIL yield_solo[%0d] got %b want 1", c, port0.gnt); end
        end
        cycle(1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
        tests_run++; if (port1.gnt !== 1'b1 || port0.gnt !== 1'b0) begin tests_failed++; $display("FAIL yield_switch got %b%b want 01", port0.gnt, port1.gnt); end
        cycle(1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
        tests_run++; if (port1.gnt !== 1'b1 || port0.gnt !== 1'b0) begin tests_failed++; $display("FAIL yield_hold got %b%b want 01", port0.gnt, port1.gnt); end
    endtask

    task automatic test_reset_mid_read();
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.gnt !== 1'b1) begin tests_failed++; $display("FAIL midrst_accept got %b want 1", port0.gnt); end
        @(posedge clk);
        #1;
        tests_run++; if (port0.rvalid !== 1'b1 || port0.rdata !== pattern(5)) begin tests_failed++; $display("FAIL midrst_pre got v=%b d=%h want 1 %h", port0.rvalid, port0.rdata, pattern(5)); end
        port0.we  = 1'b1;
        port1.req = 1'b1;
        port1.we  = 1'b1;
        rst_n     = 1'b0;
        #1;
        tests_run++; if (port0.rvalid !== 1'b0 || port0.rdata !== 8'h00) begin tests_failed++; $display("FAIL midrst_drop got v=%b d=%h want 0 00", port0.rvalid, port0.rdata); end
        tests_run++; if (port0.gnt !== 1'b0 || port1.gnt !== 1'b0 || ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_quiet got g=%b%b we=%b want 00 0", port0.gnt, port1.gnt, ram_write_en); end
        port0.req = 1'b0; port0.we = 1'b0;
        port1.req = 1'b0; port1.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
        tests_run++; if (port0.gnt !== 1'b1 || port1.gnt !== 1'b0) begin tests_failed++; $display("FAIL midrst_tie got %b%b want 10", port0.gnt, port1.gnt); end
        tests_run++; if (port0.rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_late_rvalid got %b want 0", port0.rvalid); end
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        tests_run++; if (port0.rvalid !== 1'b1 || port0.rdata !== pattern(2)) begin tests_failed++; $display("FAIL midrst_after got v=%b d=%h want 1 %h", port0.rvalid, port0.rdata, pattern(2)); end
    endtask

    task automatic test_sweep();
        logic [7:0] vals[16];
        int         pulses = 0;
        int         k;
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'($urandom);
            if (i % 2 == 0) cycle(1'b1, 1'b1, 4'(i), vals[i], 1'b0, 1'b0, 4'd0, 8'h00);
            else            cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'(i), vals[i]);
            tests_run++; if (port0.gnt !== (i % 2 == 0) || port1.gnt !== (i % 2 == 1) || ram_write_en !== 1'b1) begin tests_failed++; $display("FAIL sweep_wr[%0d] got g=%b%b we=%b", i, port0.gnt, port1.gnt, ram_write_en); end
        end
        for (int i = 0; i < 17; i++) begin
            if (i < 16 && i % 2 == 0)  cycle(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
            else if (i < 16)           cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'(i), 8'h00);
            else                       cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
            if (port0.rvalid === 1'b1 || port1.rvalid === 1'b1) pulses++;
            if (i == 0) begin
                tests_run++; if (port0.rvalid !== 1'b0 || port1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL sweep_wr_rvalid got %b%b want 00", port0.rvalid, port1.rvalid); end
            end else begin
                k = i - 1;
                tests_run++;
                if (((k % 2 == 0) ? port0.rvalid : port1.rvalid) !== 1'b1 ||
                    ((k % 2 == 0) ? port0.rdata : port1.rdata) !== vals[k]) begin
                    tests_failed++; $display("FAIL sweep_rd[%0d] got v=%b%b d=%h/%h want %h", k, port0.rvalid, port1.rvalid, port0.rdata, port1.rdata, vals[k]);
                end
            end
        end
        tests_run++; if (pulses != 16) begin tests_failed++; $display("FAIL sweep_pulses got %0d want 16", pulses); end
    endtask

    task automatic test_random();
        logic       r0, r1, w0, w1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic       pend_v0 = 1'b0;
        logic       pend_v1 = 1'b0;
        logic [7:0] pend_d = 8'h00;
        logic [3:0] last_addr = 4'd0;
        logic [3:0] ga;
        logic [7:0] gd;
        logic       gw;
        int         g;
        do_reset(1'b1);
        acc_hist.delete();
        last_acc = 1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            w0 = ($urandom_range(0, 2) == 0);
            w1 = ($urandom_range(0, 2) == 0);
            a0 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom_range(0, 15));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            cycle(r0, w0, a0, d0, r1, w1, a1, d1);
            g  = exp_grant(r0, r1);
            ga = (g == 0) ? a0 : (g == 1) ? a1 : last_addr;
            gd = (g == 0) ? d0 : (g == 1) ? d1 : 8'h00;
            gw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
            tests_run++; if (port0.gnt !== (g == 0) || port1.gnt !== (g == 1)) begin tests_failed++; $display("FAIL rand_gnt[%0d] got %b%b want owner %0d", n, port0.gnt, port1.gnt, g); end
            tests_run++; if (port0.rvalid !== pend_v0 || port1.rvalid !== pend_v1) begin tests_failed++; $display("FAIL rand_rvalid[%0d] got %b%b want %b%b", n, port0.rvalid, port1.rvalid, pend_v0, pend_v1); end
            tests_run++; if (port0.rdata !== (pend_v0 ? pend_d : 8'h00) || port1.rdata !== (pend_v1 ? pend_d : 8'h00)) begin tests_failed++; $display("FAIL rand_rdata[%0d] got %h/%h want %h", n, port0.rdata, port1.rdata, pend_d); end
            tests_run++; if (ram_write_en !== gw || ram_address !== ga || ram_data_in !== gd) begin tests_failed++; $display("FAIL rand_bus[%0d] got we=%b a=%h d=%h want %b %h %h", n, ram_write_en, ram_address, ram_data_in, gw, ga, gd); end
            acc_hist.push_back(g);
            if (acc_hist.size() > 32) void'(acc_hist.pop_front());
            pend_v0 = (g == 0) && !w0;
            pend_v1 = (g == 1) && !w1;
            if (g >= 0) begin
                last_acc  = g;
                last_addr = ga;
                if (gw) model_mem[ga] = gd;
                else    pend_d = model_mem[ga];
            end
        end
    endtask

    initial begin
        port0.req = 1'b0; port0.we = 1'b0; port0.addr = '0; port0.wdata = '0;
        port1.req = 1'b0; port1.we = 1'b0; port1.addr = '0; port1.wdata = '0;
        test_reset();
        test_single();
        test_tie();
        test_isolation();
        test_burst_yield();
        test_reset_mid_read();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish within 200000 ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16 x 8-bit single-port synchronous-read RAM.
- Shares the RAM's single address/data/write_en port between two clients using a req/gnt handshake.
- Round-robin fairness with a bounded burst length.
- Returns read data to the owning client with a one-cycle rvalid strobe, matching the RAM's registered-address read latency.

Parameters:
- ADDR_W, 4, RAM address width (16 locations)
- DATA_W, 8, RAM word width
- BURST_MAX, 4, max consecutive accepted transactions for one owner while the other requester is waiting; legal range 1..15

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 transaction request
- we0  in  1  requester 0 write (1) / read (0)
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 grant; transaction accepted at posedge when req0 & gnt0
- rvalid0  out  1  requester 0 read data valid
- rdata0  out  DATA_W  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM data_in
- ram_write_en  out  1  to RAM write_en, active high
- ram_data_out  in  DATA_W  from RAM data_out

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_owner=1 (so requester 0 wins the first tie), burst_cnt=0.
  - rvalid0/1=0, rd_owner regs cleared.
  - gnt0/1 forced 0 while rst_n low; ram_write_en=0.
- Reset mid-transaction: a pending rvalid is dropped, not delivered after reset release.
- State register: IDLE, OWN0, OWN1 = owner accepted in the previous cycle.
- Grant (combinational from state, burst_cnt, req0, req1); at most one gnt high per cycle:
  - No req: no grant; next state IDLE.
  - Single req: that requester is granted, regardless of burst_cnt.
  - Both req, state IDLE: grant the requester != last_owner.
  - Both req, state OWNk, burst_cnt < BURST_MAX: grant k.
  - Both req, state OWNk, burst_cnt == BURST_MAX: grant the other requester.
- Next state = OWNk if gnt_k & req_k, else IDLE. last_owner updates to k on each accepted transaction.
- burst_cnt:
  - Set to 1 on a transaction by a new owner (including from IDLE).
  - Incremented on each further consecutive transaction by the same owner.
  - Saturates at BURST_MAX.
  - Cleared on an IDLE cycle.
- RAM port mux (combinational from the granted requester):
  - ram_address=addr_k; ram_data_in=wdata_k; ram_write_en=we_k & req_k & gnt_k.
  - No grant: ram_write_en=0; ram_address holds the last granted address (registered copy) to avoid toggling; ram_data_in=0.
- Read return:
  - Read accepted at edge N -> rvalid_k high for exactly the cycle after edge N; rdata_k = ram_data_out during that cycle.
  - rdata_k = 0 when rvalid_k is low.
  - Back-to-back reads give back-to-back rvalid pulses.
  - Writes produce no rvalid.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data (RAM write and address register update on the same edge).
- Address wrap: addresses are used verbatim, no increment logic; all 16 locations are reachable.
- Simultaneous write by one requester and a waiting read by the other: serialized by arbitration, never merged.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2), default ADDR_W/DATA_W.
- One natural sub-module, rr_grant2: 2-way round-robin grant with burst counter (inputs req0, req1, state, burst_cnt; outputs gnt0, gnt1).
- The arbiter top adds the RAM mux and read-return pipeline and instantiates ram_sp_sync_read in the bench only.

Test Plan:
- Single requester: req0 writes 8'hA5 to addr 3, then reads addr 3 -> gnt0 each cycle, rvalid0 high one cycle after read accept, rdata0=8'hA5; gnt1, rvalid1 stay 0.
- Tie after reset: req0 and req1 both reading from the first cycle, BURST_MAX=4 -> grants 0,0,0,0,1,1,1,1,0… and each rvalid_k pulse aligns with its owner's accepted read.
- Isolation: req1 writes 8'h3C to addr 15 while req0 repeatedly reads addr 15 -> req0 sees old data until the cycle after the write edge, then 8'h3C; never a concurrent gnt.
- Burst yield: req0 held high, req1 asserted after 6 req0 transactions -> gnt1 on the very next cycle (burst_cnt already saturated at 4).
- Reset mid-read: rst_n low asynchronously between read accept and the return cycle -> rvalid0 stays 0, gnt0/1=0, ram_write_en=0; after release the first tie grants requester 0.
- Sweep: write $random to all 16 addresses via alternating requesters, then read all back -> 16 rvalid pulses, all compare equal with ===, error_count=0.
